// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port bypassed register file.
// Holds the default geometry, the select-width helper and the
// register-index type used by the register file and its sub-modules.
package regfile_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_REGS = 8;

  // Select width for a file of n registers; never narrower than one bit.
  function automatic int regfile_aw(input int n);
    int w;
    if (n <= 2) w = 1;
    else        w = $clog2(n);
    return w;
  endfunction

  localparam int DEF_AW = regfile_aw(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register priority write select.
// For every register, finds the lowest-index active write port that targets
// it and forwards that port's data. The same result feeds both the storage
// update and the read bypass, so both always agree on the winner.
// Ports:
//   wr_en      in  NUM_WR           write enables
//   wr_sel     in  NUM_WR*AW        write selects, port k in [k*AW +: AW]
//   wr_data    in  NUM_WR*WIDTH     write data, port k in [k*WIDTH +: WIDTH]
//   hit        out NUM_REGS         register r is written this cycle
//   win_data   out NUM_REGS*WIDTH   winning data for register r
//   collision  out 1                two or more active ports share a target
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int AW       = regfile_aw(NUM_REGS)
) (
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*AW-1:0]      wr_sel,
  input  logic [NUM_WR*WIDTH-1:0]   wr_data,
  output logic [NUM_REGS-1:0]       hit,
  output logic [NUM_REGS*WIDTH-1:0] win_data,
  output logic                      collision
);

  always_comb begin
    hit       = '0;
    win_data  = '0;
    collision = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      // Scan from port 0 upward: the first match claims the register,
      // any later match on the same register is a collision.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_sel[k*AW +: AW] == AW'(r))) begin
          if (hit[r]) begin
            collision = 1'b1;
          end else begin
            hit[r]                       = 1'b1;
            win_data[r*WIDTH +: WIDTH]   = wr_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_bypass_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a
// per-register pending scoreboard for decode-stage operand stalls.
// Ports:
//   clk       in  1               rising-edge clock
//   rst       in  1               asynchronous reset, active-low
//   rd_sel    in  NUM_RD*AW       read selects, port i in [i*AW +: AW]
//   rd_data   out NUM_RD*WIDTH    read data (bypassed from writes)
//   rd_ready  out NUM_RD          operand usable this cycle
//   wr_en     in  NUM_WR          write enables (port 0 highest priority)
//   wr_sel    in  NUM_WR*AW       write selects
//   wr_data   in  NUM_WR*WIDTH    write data
//   rsv_en    in  1               reserve request for rsv_sel
//   rsv_sel   in  AW              register being reserved
//   pending   out NUM_REGS        scoreboard, one bit per register
//   err       out 1               sticky error flag
module regfile_bypass_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*regfile_aw(NUM_REGS)-1:0] rd_sel,
  output logic [NUM_RD*WIDTH-1:0]        rd_data,
  output logic [NUM_RD-1:0]              rd_ready,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*regfile_aw(NUM_REGS)-1:0] wr_sel,
  input  logic [NUM_WR*WIDTH-1:0]        wr_data,
  input  logic                           rsv_en,
  input  logic [regfile_aw(NUM_REGS)-1:0] rsv_sel,
  output logic [NUM_REGS-1:0]            pending,
  output logic                           err
);

  localparam int AW = regfile_aw(NUM_REGS);

  logic [WIDTH-1:0]          regs_q [NUM_REGS];
  logic [WIDTH-1:0]          regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]       pending_q, pending_d;
  logic                      err_q, err_d;

  logic [NUM_REGS-1:0]       hit;
  logic [NUM_REGS*WIDTH-1:0] win_data;
  logic                      collision;

  regfile_wr_arb #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_wr_arb (
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .hit       (hit),
    .win_data  (win_data),
    .collision (collision)
  );

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (hit[r]) regs_d[r] = win_data[r*WIDTH +: WIDTH];
      // A new reservation supersedes the in-flight producer, so it beats a
      // write-back landing in the same cycle; the data still commits.
      if (rsv_en && (rsv_sel == AW'(r))) pending_d[r] = 1'b1;
      else if (hit[r])                    pending_d[r] = 1'b0;
    end
    // Re-reserving a busy register is only legal when its write-back
    // retires in the same cycle.
    err_d = err_q | collision | (rsv_en & pending_q[rsv_sel] & ~hit[rsv_sel]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Read ports: a same-cycle write to the selected register bypasses
  // storage and also makes the operand ready despite a pending bit.
  always_comb begin
    logic [AW-1:0] sel;
    rd_data  = '0;
    rd_ready = '0;
    sel      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      sel = rd_sel[i*AW +: AW];
      rd_data[i*WIDTH +: WIDTH] = hit[sel] ? win_data[sel*WIDTH +: WIDTH] : regs_q[sel];
      rd_ready[i]               = ~pending_q[sel] | hit[sel];
    end
  end

  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: tb/tb_regfile_bypass_mp.sv
module tb_regfile_bypass_mp;
  import regfile_pkg::*;

  localparam int W  = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2*AW-1:0] rd_sel = '0;
  logic [2*W-1:0]  rd_data;
  logic [1:0]      rd_ready;
  logic [1:0]      wr_en = '0;
  logic [2*AW-1:0] wr_sel = '0;
  logic [2*W-1:0]  wr_data = '0;
  logic            rsv_en = 1'b0;
  reg_idx_t        rsv_sel = '0;
  logic [NR-1:0]   pending;
  logic            err;

  regfile_bypass_mp #(.WIDTH(W), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .pending  (pending),
    .err      (err)
  );

  always #5 clk = ~clk;

  // kind: 0 rd_data[idx], 1 rd_ready[idx], 2 pending, 3 err
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input int kind, input int idx, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic wr(input int port, input int sel, input logic [15:0] d);
    wr_en[port]             = 1'b1;
    wr_sel[port*AW +: AW]   = AW'(sel);
    wr_data[port*W +: W]    = d;
  endtask

  task automatic rd(input int port, input int sel);
    rd_sel[port*AW +: AW] = AW'(sel);
  endtask

  task automatic rsv(input int sel);
    rsv_en  = 1'b1;
    rsv_sel = reg_idx_t'(sel);
  endtask

  // Monitor: drains every expectation queued for this cycle, away from the
  // active edge.
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_act = '0;
      case (m_e.kind)
        0:       m_act = 32'(rd_data[m_e.idx*W +: W]);
        1:       m_act = 32'(rd_ready[m_e.idx]);
        2:       m_act = 32'(pending);
        default: m_act = 32'(err);
      endcase
      total++;
      if (m_act !== m_e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", m_e.name, m_act, m_e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    repeat (2) step();
    rst = 1'b1;

    // Reset state on every register through both ports
    for (int r = 0; r < NR; r++) begin
      step();
      rd(0, r); rd(1, NR-1-r);
      push(0, 0, 32'h0, "rst_rd0");
      push(0, 1, 32'h0, "rst_rd1");
      push(1, 0, 32'h1, "rst_rdy0");
      push(1, 1, 32'h1, "rst_rdy1");
      push(2, 0, 32'h0, "rst_pending");
      push(3, 0, 32'h0, "rst_err");
    end

    // Same-cycle bypass, then stored value
    step();
    wr(0, 3, 16'hBEEF); rd(0, 3); rd(1, 3);
    push(0, 0, 32'hBEEF, "byp_r3_p0");
    push(0, 1, 32'hBEEF, "byp_r3_p1");
    push(1, 0, 32'h1, "byp_r3_rdy");
    step();
    idle(); rd(0, 3);
    push(0, 0, 32'hBEEF, "stored_r3");

    // Write collision: port 0 wins, err sticky
    step();
    wr(0, 5, 16'h1111); wr(1, 5, 16'h2222); rd(0, 5); rd(1, 5);
    push(0, 0, 32'h1111, "coll_byp_p0");
    push(0, 1, 32'h1111, "coll_byp_p1");
    push(3, 0, 32'h0, "coll_err_pre");
    step();
    idle(); rd(0, 5);
    push(0, 0, 32'h1111, "coll_stored");
    push(3, 0, 32'h1, "coll_err");

    // Reserve r2, stall, then write-back releases it
    step();
    rsv(2);
    step();
    idle(); rd(0, 2);
    push(1, 0, 32'h0, "r2_stall");
    push(2, 0, 32'h04, "r2_pending");
    step();
    wr(1, 2, 16'h00AA); rd(0, 2);
    push(1, 0, 32'h1, "r2_wb_rdy");
    push(0, 0, 32'h00AA, "r2_wb_data");
    step();
    idle(); rd(0, 2);
    push(2, 0, 32'h0, "r2_cleared");
    push(0, 0, 32'h00AA, "r2_stored");
    push(3, 0, 32'h1, "err_sticky");

    // Reset pulse to clear err before the reserve-error checks
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    push(3, 0, 32'h0, "err_after_rst");

    // Reserve and write r4 in the same cycle
    step();
    rsv(4); wr(0, 4, 16'h0044);
    step();
    idle(); rd(0, 4);
    push(2, 0, 32'h10, "r4_pending");
    push(0, 0, 32'h0044, "r4_stored");
    push(1, 0, 32'h0, "r4_stall");
    push(3, 0, 32'h0, "r4_err_clean");
    // Re-reserve while pending but with a retiring write: legal
    step();
    rsv(4); wr(1, 4, 16'h4545);
    step();
    idle(); rd(0, 4);
    push(2, 0, 32'h10, "r4_rersv_pend");
    push(0, 0, 32'h4545, "r4_rersv_data");
    push(3, 0, 32'h0, "r4_rersv_err");
    // Re-reserve while pending with no write: error
    step();
    rsv(4);
    step();
    idle();
    push(3, 0, 32'h1, "r4_dbl_rsv_err");
    push(2, 0, 32'h10, "r4_dbl_pend");

    // Fill the scoreboard, then reset mid-cycle
    for (int r = 0; r < NR; r++) begin
      step();
      idle(); rsv(r);
      if (r == 0) wr(0, 3, 16'h3333);
    end
    step();
    idle(); rd(0, 3);
    push(2, 0, 32'hFF, "full_pending");
    push(0, 0, 32'h3333, "full_r3");
    push(1, 0, 32'h0, "full_stall");
    push(3, 0, 32'h1, "full_err");
    step();
    rst = 1'b0;
    wr(0, 1, 16'h0F0F); rd(0, 3); rd(1, 1);
    push(2, 0, 32'h0, "async_pending");
    push(3, 0, 32'h0, "async_err");
    push(0, 0, 32'h0, "async_r3");
    push(1, 0, 32'h1, "async_rdy0");
    push(0, 1, 32'h0F0F, "async_byp");
    push(1, 1, 32'h1, "async_rdy1");
    step();
    rst = 1'b1;
    idle();

    // Bounded drain of any outstanding expectations
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
